// File: rtl/reg_writeback_if.sv
// Writeback channel bundle: ALU and load producers in, register-file write
// port and status out.
interface reg_writeback_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
);
    logic                          alu_valid;
    logic                          alu_ready;
    logic [ADDRESS_WIDTH-1:0]      alu_rd;
    logic [DATA_WIDTH-1:0]         alu_result;
    logic                          ld_valid;
    logic                          ld_ready;
    logic [ADDRESS_WIDTH-1:0]      ld_rd;
    logic [DATA_WIDTH-1:0]         ld_data;
    logic                          WE3;
    logic [ADDRESS_WIDTH-1:0]      A3;
    logic [DATA_WIDTH-1:0]         WD3;
    logic [DATA_WIDTH-1:0]         a0;
    logic [(1<<ADDRESS_WIDTH)-1:0] pending_mask;

    // Producer side (pipeline / testbench)
    modport master (
        output alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready, WE3, A3, WD3, a0, pending_mask
    );

    // Writeback block side
    modport slave (
        input  alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready, WE3, A3, WD3, a0, pending_mask
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: merges ALU results with a small load-result
// FIFO into a single registered write port, tracks outstanding destinations
// and shadows x10 (a0).
module reg_writeback #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned LD_DEPTH      = 2
) (
    input logic           clk,
    input logic           rst_n,
    reg_writeback_if.slave bus
);
    localparam int unsigned PtrW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned Regs = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0Idx = ADDRESS_WIDTH'(10);

    typedef logic [PtrW-1:0] ptr_t;

    logic [ADDRESS_WIDTH-1:0] rd_mem   [LD_DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [LD_DEPTH];
    logic [LD_DEPTH-1:0]      vld_q, vld_d;
    ptr_t                     wr_ptr, rd_ptr;
    logic                     run_q;
    logic                     full, empty, ready, push, pop, alu_take, win;
    logic [ADDRESS_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0]    win_data;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] a3_q;
    logic [DATA_WIDTH-1:0]    wd3_q, a0_q;
    logic [Regs-1:0]          mask;

    function automatic ptr_t ptr_inc(ptr_t p);
        if (int'(p) == int'(LD_DEPTH) - 1) return '0;
        return p + ptr_t'(1);
    endfunction

    // Handshake, arbitration and FIFO occupancy next-state
    always_comb begin
        full     = &vld_q;
        empty    = ~|vld_q;
        // run_q keeps both readies low until the first edge after reset release
        ready    = run_q && !full;
        push     = bus.ld_valid && ready;
        alu_take = bus.alu_valid && ready;
        // Full FIFO beats ALU; otherwise ALU beats a non-full FIFO
        pop      = full || (!alu_take && !empty);
        win      = pop || alu_take;
        win_rd   = pop ? rd_mem[rd_ptr]   : bus.alu_rd;
        win_data = pop ? data_mem[rd_ptr] : bus.alu_result;
        vld_d    = vld_q;
        if (pop)  vld_d[rd_ptr] = 1'b0;
        if (push) vld_d[wr_ptr] = 1'b1;
    end

    // FIFO storage; contents only matter where the matching valid bit is set
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= bus.ld_rd;
            data_mem[wr_ptr] <= bus.ld_data;
        end
    end

    // FIFO occupancy, pointers and post-reset run flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            run_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            run_q  <= 1'b1;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Output stage: register the winner; x0 winners are consumed silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q  <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            a0_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (win && (win_rd != '0)) begin
                we_q  <= 1'b1;
                a3_q  <= win_rd;
                wd3_q <= win_data;
                if (win_rd == A0Idx) a0_q <= win_data;
            end
        end
    end

    // Outstanding destinations: queued loads plus the write being presented
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(LD_DEPTH); i++) begin
            if (vld_q[i]) mask[rd_mem[i]] = 1'b1;
        end
        if (we_q) mask[a3_q] = 1'b1;
        mask[0] = 1'b0;
    end

    assign bus.alu_ready    = ready;
    assign bus.ld_ready     = ready;
    assign bus.WE3          = we_q;
    assign bus.A3           = a3_q;
    assign bus.WD3          = wd3_q;
    assign bus.a0           = a0_q;
    assign bus.pending_mask = mask;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: each cycle starts 1 time unit after the
// rising edge, where inputs are driven and outputs are sampled.
module tb_reg_writeback;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    reg_writeback_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    reg_writeback #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(5),
        .LD_DEPTH     (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid  = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_result = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_rd      = '0;
        bus.ld_data    = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = rd;
        bus.alu_result = d;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, "_we"}, 64'(bus.WE3), 64'd1);
        check({tag, "_a3"}, 64'(bus.A3), 64'(rd));
        check({tag, "_wd3"}, 64'(bus.WD3), 64'(d));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        check("rst_we", 64'(bus.WE3), 64'd0);
        check("rst_a3", 64'(bus.A3), 64'd0);
        check("rst_wd3", 64'(bus.WD3), 64'd0);
        check("rst_a0", 64'(bus.a0), 64'd0);
        check("rst_pend", 64'(bus.pending_mask), 64'd0);
        check("rst_alu_rdy", 64'(bus.alu_ready), 64'd0);
        check("rst_ld_rdy", 64'(bus.ld_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rel_alu_rdy", 64'(bus.alu_ready), 64'd1);
        check("rel_ld_rdy", 64'(bus.ld_ready), 64'd1);

        // ALU write, one-cycle latency, single pulse
        drive_alu(5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        check_write("alu", 5'd5, 32'hDEAD_BEEF);
        check("alu_pend", 64'(bus.pending_mask), 64'h0000_0020);
        tick();
        check("alu_we_off", 64'(bus.WE3), 64'd0);
        check("alu_a3_hold", 64'(bus.A3), 64'd5);
        check("alu_wd3_hold", 64'(bus.WD3), 64'hDEAD_BEEF);

        // Load to x10 with ALU idle: two-cycle latency, a0 shadow
        drive_ld(5'd10, 32'h0000_1234);
        tick();
        idle();
        check("ld_n1_we", 64'(bus.WE3), 64'd0);
        check("ld_n1_pend", 64'(bus.pending_mask), 64'h0000_0400);
        tick();
        check_write("ld_n2", 5'd10, 32'h0000_1234);
        check("ld_n2_a0", 64'(bus.a0), 64'h0000_1234);
        check("ld_n2_pend", 64'(bus.pending_mask), 64'h0000_0400);
        tick();
        check("ld_n3_pend", 64'(bus.pending_mask), 64'd0);
        check("ld_n3_we", 64'(bus.WE3), 64'd0);
        check("ld_n3_a0", 64'(bus.a0), 64'h0000_1234);

        // Fill the FIFO while the ALU keeps winning, then drain
        drive_alu(5'd20, 32'h0000_AAAA);
        drive_ld(5'd3, 32'h0000_3333);
        tick();
        check_write("full_alu20", 5'd20, 32'h0000_AAAA);
        drive_alu(5'd21, 32'h0000_BBBB);
        drive_ld(5'd4, 32'h0000_4444);
        tick();
        check_write("full_alu21", 5'd21, 32'h0000_BBBB);
        check("full_ld_rdy", 64'(bus.ld_ready), 64'd0);
        check("full_alu_rdy", 64'(bus.alu_ready), 64'd0);
        check("full_pend", 64'(bus.pending_mask), 64'h0020_0018);
        bus.ld_valid = 1'b0;
        drive_alu(5'd22, 32'h0000_CCCC);
        tick();
        check_write("full_x3", 5'd3, 32'h0000_3333);
        check("drain_ld_rdy", 64'(bus.ld_ready), 64'd1);
        check("drain_alu_rdy", 64'(bus.alu_ready), 64'd1);
        bus.alu_valid = 1'b0;
        tick();
        check_write("full_x4", 5'd4, 32'h0000_4444);
        drive_alu(5'd22, 32'h0000_CCCC);
        tick();
        idle();
        check_write("full_alu22", 5'd22, 32'h0000_CCCC);
        tick();

        // x0 writes are swallowed
        drive_alu(5'd0, 32'h0000_1111);
        drive_ld(5'd0, 32'h0000_2222);
        tick();
        idle();
        check("x0_alu_we", 64'(bus.WE3), 64'd0);
        check("x0_pend", 64'(bus.pending_mask), 64'd0);
        tick();
        check("x0_ld_we", 64'(bus.WE3), 64'd0);
        check("x0_a3", 64'(bus.A3), 64'd22);
        check("x0_wd3", 64'(bus.WD3), 64'h0000_CCCC);

        // Same destination twice keeps push order
        drive_ld(5'd7, 32'h0000_0001);
        tick();
        check("x7_pend", 64'(bus.pending_mask), 64'h0000_0080);
        drive_ld(5'd7, 32'h0000_0002);
        tick();
        idle();
        check_write("x7_first", 5'd7, 32'h0000_0001);
        tick();
        check_write("x7_second", 5'd7, 32'h0000_0002);
        tick();
        check("x7_done_we", 64'(bus.WE3), 64'd0);
        check("x7_done_pend", 64'(bus.pending_mask), 64'd0);

        // Reset with two loads queued behind a busy ALU
        drive_alu(5'd1, 32'h0000_0011);
        drive_ld(5'd8, 32'h0000_0008);
        tick();
        drive_alu(5'd2, 32'h0000_0022);
        drive_ld(5'd9, 32'h0000_0009);
        tick();
        idle();
        check("rst2_pre_pend", 64'(bus.pending_mask), 64'h0000_0304);
        rst_n = 1'b0;
        #1;
        check("rst2_we", 64'(bus.WE3), 64'd0);
        check("rst2_pend", 64'(bus.pending_mask), 64'd0);
        check("rst2_rdy", 64'(bus.ld_ready), 64'd0);
        check("rst2_a3", 64'(bus.A3), 64'd0);
        check("rst2_a0", 64'(bus.a0), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst2_rel_rdy", 64'(bus.alu_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst2_stale_we%0d", i), 64'(bus.WE3), 64'd0);
            check($sformatf("rst2_stale_pend%0d", i), 64'(bus.pending_mask), 64'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
